// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
//   Shared definitions for the dot-product MAC sequencer: the FSM state
//   encoding and width helpers for the result bus and the pair counter.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } mac_ctrl_state_e;

  // The MAC result is three operand widths wide.
  function automatic int calc_result_w(input int data_width);
    return 3 * data_width;
  endfunction

  // The counter must be able to hold VEC_LEN itself.
  function automatic int calc_cnt_w(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl
//   Sequences one external MAC through a fixed-length dot product. Clears
//   the accumulator, feeds VEC_LEN accepted operand pairs (gating En per
//   pair), waits one cycle for the last accumulation, then presents Cout on
//   a valid/ready result port. Contains no arithmetic.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a vector (IDLE only) / cancel to IDLE
//   busy                high whenever not IDLE
//   in_a, in_b          operand pair; in_valid/in_ready handshake
//   mac_en, mac_clr     MAC En / Clr strobes
//   mac_ain, mac_bin    registered operands to the MAC
//   mac_cout            accumulator value from the MAC
//   res_data            result (zero outside OUT); res_valid/res_ready
module mac_dot_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  localparam int RESULT_W  = calc_result_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_ain,
  output logic [DATA_WIDTH-1:0] mac_bin,
  input  logic [RESULT_W-1:0]   mac_cout,
  output logic [RESULT_W-1:0]   res_data,
  output logic                  res_valid,
  input  logic                  res_ready
);

  localparam int CNT_W = calc_cnt_w(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  mac_ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ain_q, ain_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic                  en_q, en_d;
  logic                  accept;

  // in_ready is purely a function of state, so there is no path from
  // in_valid back to in_ready.
  assign accept = in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ain_d   = ain_q;
    bin_d   = bin_q;
    en_d    = 1'b0;   // En is only ever high the cycle after an accept

    if (abort && (state_q != ST_IDLE)) begin
      // Abort beats a simultaneous handshake: the pair is not counted and
      // En is not raised. The MAC is left dirty until the next CLEAR.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (accept) begin
            ain_d = in_a;
            bin_d = in_b;
            en_d  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // En carries the last pair during this cycle; the MAC absorbs it
          // at the closing edge, so Cout is final once we reach OUT.
          state_d = ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ain_q   <= '0;
      bin_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
      en_q    <= en_d;
    end
  end

  // All control outputs decode the registered state, so they are glitch-free
  // and fall to their reset values as soon as rst_n asserts.
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_ACCUM);
  assign mac_clr   = (state_q == ST_CLEAR);
  assign mac_en    = en_q;
  assign mac_ain   = ain_q;
  assign mac_bin   = bin_q;
  assign res_valid = (state_q == ST_OUT);
  assign res_data  = (state_q == ST_OUT) ? mac_cout : '0;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl
//   Directed bench for mac_dot_ctrl. A behavioural MAC sits beside the DUT
//   exactly as the parent would instantiate it; expected dot products are
//   hand-computed constants.
module tb_mac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid, res_ready;
  logic [7:0]  in_a, in_b;
  logic        busy, in_ready, mac_en, mac_clr, res_valid;
  logic [7:0]  mac_ain, mac_bin;
  logic [23:0] mac_cout, res_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_dot_ctrl #(.DATA_WIDTH(8), .VEC_LEN(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_ain  (mac_ain),
    .mac_bin  (mac_bin),
    .mac_cout (mac_cout),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // Sibling MAC: Clr zeroes, En accumulates Ain*Bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + 24'(mac_ain) * 24'(mac_bin);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one full vector. ramp=1 uses pairs (i+1,i+1), else (a0,b0).
  // toggle=1 alternates in_valid; hold>0 stalls res_ready in OUT and pulses
  // start meanwhile. exp_lat>0 checks the start-to-res_valid edge count.
  task automatic run_vec(input string name, input logic [7:0] a0, input logic [7:0] b0,
                         input bit ramp, input bit toggle, input int hold,
                         input logic [23:0] exp_res, input int exp_lat);
    int  lat;
    int  idx;
    int  guard;
    bit  phase;
    bit  acc;
    logic [23:0] held;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    chk({name, "_clr"}, {31'd0, mac_clr}, 32'd1);
    chk({name, "_clr_en"}, {31'd0, mac_en}, 32'd0);
    idx = 0; guard = 0; phase = 1'b1;
    while (idx < 8 && guard < 100) begin
      in_a     = ramp ? 8'(idx + 1) : a0;
      in_b     = ramp ? 8'(idx + 1) : b0;
      in_valid = toggle ? phase : 1'b1;
      acc      = in_valid && in_ready;
      step();
      lat++; guard++;
      if (acc) idx++;
      phase = ~phase;
      if (toggle) chk({name, "_en_gate"}, {31'd0, mac_en}, {31'd0, acc});
    end
    in_valid = 1'b0;
    chk({name, "_pairs"}, idx, 8);
    chk({name, "_drain_en"}, {31'd0, mac_en}, 32'd1);
    guard = 0;
    while (!res_valid && guard < 20) begin
      step();
      lat++; guard++;
    end
    chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    if (exp_lat > 0) chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_data"}, {8'd0, res_data}, {8'd0, exp_res});
    chk({name, "_out_en"}, {31'd0, mac_en}, 32'd0);
    held = res_data;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      step();
      chk({name, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
      chk({name, "_hold_data"}, {8'd0, res_data}, {8'd0, held});
      chk({name, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
      chk({name, "_hold_busy"}, {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
    chk({name, "_idle_data"}, {8'd0, res_data}, 32'd0);
    $display("vector %s: result=%0d latency=%0d", name, held, lat);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"},  {31'd0, busy},      32'd0);
    chk({name, "_rdy"},   {31'd0, in_ready},  32'd0);
    chk({name, "_en"},    {31'd0, mac_en},    32'd0);
    chk({name, "_clr"},   {31'd0, mac_clr},   32'd0);
    chk({name, "_valid"}, {31'd0, res_valid}, 32'd0);
    chk({name, "_ain"},   {24'd0, mac_ain},   32'd0);
    chk({name, "_bin"},   {24'd0, mac_bin},   32'd0);
    chk({name, "_data"},  {8'd0, res_data},   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    res_ready = 1'b0; in_a = '0; in_b = '0;
    step(); step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    run_vec("v8x8",  8'd8,   8'd8,   1'b0, 1'b0, 0, 24'd512,    11);
    run_vec("v255",  8'd255, 8'd255, 1'b0, 1'b0, 0, 24'd520200, 11);
    run_vec("v2x2",  8'd2,   8'd2,   1'b0, 1'b0, 0, 24'd32,     11);
    run_vec("ramp",  8'd0,   8'd0,   1'b1, 1'b1, 0, 24'd204,    0);
    run_vec("stall", 8'd3,   8'd3,   1'b0, 1'b0, 5, 24'd72,     11);

    // Abort after three (5,5) pairs, with a fourth handshake in flight.
    start = 1'b1; step(); start = 1'b0;
    in_a = 8'd5; in_b = 8'd5; in_valid = 1'b1;
    step();            // CLEAR -> ACCUM
    step(); step(); step();
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_rdy",   {31'd0, in_ready},  32'd0);
    chk("abort_en",    {31'd0, mac_en},    32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    $display("abort: busy=%0d in_ready=%0d", busy, in_ready);
    run_vec("after_abort", 8'd1, 8'd1, 1'b0, 1'b0, 0, 24'd8, 11);

    // Asynchronous reset in the middle of ACCUM.
    start = 1'b1; step(); start = 1'b0;
    in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1;
    step(); step(); step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    $display("async reset: busy=%0d mac_en=%0d", busy, mac_en);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_vec("after_rst", 8'd3, 8'd4, 1'b0, 1'b0, 0, 24'd96, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
